// File: rtl/mem_boot_loader.sv
// mem_boot_loader: framed byte-stream boot loader feeding SRAM port 2.
// Frame = A5, LEN_HI, LEN_LO, 4*N data bytes (big-endian words), XOR CSUM.
// Ports: i_clk/i_rst (async active-low), byte stream in (valid/ready),
//        registered SRAM write port out (addr/wdata/bwe), cpu_hold,
//        load_done (level) and load_err (sticky until the next sync byte).
// Write latency: one cycle after the 4th data byte is accepted; one byte/cycle max.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif

module mem_boot_loader #(
  parameter int          ADDR_W    = `MEM_ADDR_WIDTH,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bwe,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Datapath registers
  logic [15:0]       r_count;     // frame word count N
  logic [15:0]       r_word_idx;  // words written so far in this frame
  logic [1:0]        r_byte_cnt;  // byte position inside the current word
  logic [23:0]       r_word;      // first three bytes of the word being assembled
  logic [7:0]        r_acc;       // running XOR of data bytes
  logic [ADDR_W-1:0] r_waddr;     // address the next completed word goes to
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_bwe;
  logic              r_load_err;

  // Control strobes from the FSM to the datapath
  logic w_ready;
  logic w_accept;
  logic w_start;
  logic w_len_hi;
  logic w_len_lo;
  logic w_data;
  logic w_wr;
  logic w_csum_bad;
  logic w_last_word;
  logic [15:0] w_len_full;

  assign w_ready     = (r_state != S_DONE);
  assign w_accept    = i_byte_valid & w_ready;
  // In DATA the count is known to be non-zero, so N-1 does not underflow.
  assign w_last_word = (r_word_idx == (r_count - 16'd1));
  assign w_len_full  = {r_count[15:8], i_byte_data};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath strobes. Nothing moves unless a byte is accepted,
  // so gaps in i_byte_valid simply stall the frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_len_hi    = 1'b0;
    w_len_lo    = 1'b0;
    w_data      = 1'b0;
    w_wr        = 1'b0;
    w_csum_bad  = 1'b0;

    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          // Anything other than the sync byte is line noise and is dropped.
          if (i_byte_data == SYNC_BYTE) begin
            w_start     = 1'b1;
            w_state_nxt = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          w_len_hi    = 1'b1;
          w_state_nxt = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_len_lo    = 1'b1;
          w_state_nxt = (w_len_full != 16'd0) ? S_DATA : S_CSUM;
        end
        S_DATA: begin
          w_data = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_wr = 1'b1;
            if (w_last_word) begin
              w_state_nxt = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (i_byte_data == r_acc) begin
            w_state_nxt = S_DONE;
          end else begin
            w_csum_bad  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          // S_DONE never accepts; any illegal encoding falls back to IDLE.
          if (r_state != S_DONE) begin
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: length latch, word assembly, checksum, SRAM write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count     <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_word      <= 24'd0;
      r_acc       <= 8'd0;
      r_waddr     <= ADDR_W'(BASE_WORD);
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_bwe   <= 4'h0;
      r_load_err  <= 1'b0;
    end else begin
      // Byte enables are a single-cycle pulse; address/data hold afterwards.
      r_mem_bwe <= w_wr ? 4'hF : 4'h0;

      if (w_start) begin
        r_acc      <= 8'd0;
        r_load_err <= 1'b0;
        r_word_idx <= 16'd0;
        r_byte_cnt <= 2'd0;
        r_waddr    <= ADDR_W'(BASE_WORD);
      end

      if (w_len_hi) begin
        r_count[15:8] <= i_byte_data;
      end

      if (w_len_lo) begin
        r_count[7:0] <= i_byte_data;
      end

      if (w_data) begin
        r_word     <= {r_word[15:0], i_byte_data};
        r_acc      <= r_acc ^ i_byte_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      if (w_wr) begin
        r_mem_addr  <= r_waddr;
        r_mem_wdata <= {r_word, i_byte_data};
        // Natural ADDR_W-bit overflow gives the wrap from the top word to 0.
        r_waddr     <= r_waddr + ADDR_W'(1);
        r_word_idx  <= r_word_idx + 16'd1;
      end

      if (w_csum_bad) begin
        r_load_err <= 1'b1;
      end
    end
  end

  assign o_byte_ready = w_ready;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_bwe    = r_mem_bwe;
  assign o_load_done  = (r_state == S_DONE);
  // The processor stays in reset for every state except a verified load.
  assign o_cpu_hold   = (r_state != S_DONE);
  assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two instances share one byte stream, one at base 0
// and one at the top word of a 4-bit address space, so every frame also exercises
// address wrap. Expected writes/status come from a frame-level stream parser.

module tb_mem_boot_loader;

  localparam int A0 = 10;
  localparam int B0 = 0;
  localparam int A1 = 4;
  localparam int B1 = 15;

  logic          clk;
  logic          rst;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          ready0, ready1;
  logic [A0-1:0] addr0;
  logic [A1-1:0] addr1;
  logic [31:0]   wd0, wd1;
  logic [3:0]    bwe0, bwe1;
  logic          hold0, hold1, done0, done1, err0, err1;

  mem_boot_loader #(.ADDR_W(A0), .BASE_WORD(B0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
    .o_byte_ready(ready0), .o_mem_addr(addr0), .o_mem_wdata(wd0), .o_mem_bwe(bwe0),
    .o_cpu_hold(hold0), .o_load_done(done0), .o_load_err(err0)
  );

  mem_boot_loader #(.ADDR_W(A1), .BASE_WORD(B1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
    .o_byte_ready(ready1), .o_mem_addr(addr1), .o_mem_wdata(wd1), .o_mem_bwe(bwe1),
    .o_cpu_hold(hold1), .o_load_done(done1), .o_load_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  hist[$];     // every byte accepted since the last reset
  logic [7:0]  frm[$];      // frame under construction
  logic [31:0] exp_word[$];
  int          exp_idx[$];
  logic [A0-1:0] cap0_a[$];
  logic [31:0]   cap0_d[$];
  logic [3:0]    cap0_b[$];
  logic [A1-1:0] cap1_a[$];
  logic [31:0]   cap1_d[$];
  logic [3:0]    cap1_b[$];

  // Capture every write cycle mid-period.
  always @(negedge clk) begin
    if (rst) begin
      if (bwe0 != 4'h0) begin
        cap0_a.push_back(addr0); cap0_d.push_back(wd0); cap0_b.push_back(bwe0);
      end
      if (bwe1 != 4'h0) begin
        cap1_a.push_back(addr1); cap1_d.push_back(wd1); cap1_b.push_back(bwe1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_caps();
    cap0_a.delete(); cap0_d.delete(); cap0_b.delete();
    cap1_a.delete(); cap1_d.delete(); cap1_b.delete();
    hist.delete();
  endtask

  // Returns just after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(posedge clk);
    clear_caps();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, ready0}, 32'd1);
    check({tag, "_addr0"}, {22'd0, addr0}, 32'd0);
    check({tag, "_addr1"}, {28'd0, addr1}, 32'd0);
    check({tag, "_wdata"}, wd0, 32'd0);
    check({tag, "_bwe"}, {28'd0, bwe0}, 32'd0);
    check({tag, "_hold"}, {31'd0, hold0}, 32'd1);
    check({tag, "_done"}, {31'd0, done0}, 32'd0);
    check({tag, "_err"}, {31'd0, err0}, 32'd0);
  endtask

  // Entered and left just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data = b;
    waited = 0;
    while (!ready0 && waited < 20) begin @(posedge clk); #1; waited++; end
    if (!ready0) begin
      check("ready_timeout", {31'd0, ready0}, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    hist.push_back(b);
  endtask

  task automatic send_frm(input int max_gap);
    foreach (frm[i]) send_byte(frm[i], max_gap);
  endtask

  task automatic add_noise(input int cnt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      frm.push_back(b);
    end
  endtask

  task automatic add_frame(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    frm.push_back(8'hA5);
    frm.push_back(8'(n >> 8));
    frm.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      frm.push_back(b);
    end
    frm.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  // Frame-level reading of the accepted stream: hunt for A5, take the length,
  // gather N big-endian words, compare the XOR with the trailing byte.
  task automatic model_run(output bit done, output bit err);
    int i, n;
    logic [7:0] x;
    exp_word.delete();
    exp_idx.delete();
    done = 1'b0;
    err = 1'b0;
    i = 0;
    while (i < hist.size() && !done) begin
      if (hist[i] != 8'hA5) begin i++; continue; end
      err = 1'b0;
      i++;
      if (i + 2 > hist.size()) return;
      n = {hist[i], hist[i+1]};
      i += 2;
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > hist.size()) return;
        exp_word.push_back({hist[i], hist[i+1], hist[i+2], hist[i+3]});
        exp_idx.push_back(k);
        x = x ^ hist[i] ^ hist[i+1] ^ hist[i+2] ^ hist[i+3];
        i += 4;
      end
      if (i >= hist.size()) return;
      if (hist[i] == x) done = 1'b1; else err = 1'b1;
      i++;
    end
  endtask

  task automatic check_all(input string tag);
    bit edone, eerr;
    int m;
    model_run(edone, eerr);
    check({tag, "_wcnt0"}, cap0_a.size(), exp_word.size());
    check({tag, "_wcnt1"}, cap1_a.size(), exp_word.size());
    m = (cap0_a.size() < exp_word.size()) ? cap0_a.size() : exp_word.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr0_%0d", tag, i), {22'd0, cap0_a[i]}, (B0 + exp_idx[i]) % (1 << A0));
      check($sformatf("%s_data0_%0d", tag, i), cap0_d[i], exp_word[i]);
      check($sformatf("%s_bwe0_%0d", tag, i), {28'd0, cap0_b[i]}, 32'hF);
    end
    m = (cap1_a.size() < exp_word.size()) ? cap1_a.size() : exp_word.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr1_%0d", tag, i), {28'd0, cap1_a[i]}, (B1 + exp_idx[i]) % (1 << A1));
      check($sformatf("%s_data1_%0d", tag, i), cap1_d[i], exp_word[i]);
    end
    check({tag, "_done"}, {31'd0, done0}, {31'd0, edone});
    check({tag, "_hold"}, {31'd0, hold0}, {31'd0, !edone});
    check({tag, "_err"}, {31'd0, err0}, {31'd0, eerr});
    check({tag, "_done1"}, {31'd0, done1}, {31'd0, edone});
    check({tag, "_err1"}, {31'd0, err1}, {31'd0, eerr});
    check({tag, "_ready"}, {31'd0, ready0}, {31'd0, !edone});
  endtask

  initial begin
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #2;
    check_reset_values("in_reset");
    do_reset();
    check_reset_values("post_reset");

    // Single word with known checksum.
    frm = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frm(0);
    check_all("single");
    check("single_word", wd0, 32'hDEADBEEF);
    // DONE ignores further bytes.
    byte_valid = 1'b1;
    byte_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("done_ready", {31'd0, ready0}, 32'd0);
    end
    byte_valid = 1'b0;
    check("done_stays", {31'd0, done0}, 32'd1);

    // Zero length, good and bad checksum.
    do_reset();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frm(0);
    check_all("zero_ok");
    do_reset();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h01};
    send_frm(0);
    check_all("zero_bad");

    // Bad frame, then a good 2-word frame; err must clear on the sync byte.
    do_reset();
    frm = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    send_frm(0);
    check_all("bad1");
    frm.delete();
    add_frame(2, 1'b1);
    send_byte(frm[0], 0);
    check("retry_err_clear", {31'd0, err0}, 32'd0);
    frm.delete(0);
    send_frm(0);
    check_all("retry");

    // Leading noise and random valid gaps in a 3-word frame.
    do_reset();
    frm = '{8'h00, 8'hFF, 8'h5A};
    add_frame(3, 1'b1);
    send_frm(3);
    check_all("gaps");

    // Reset part-way through the second word, then a clean reload.
    do_reset();
    frm.delete();
    add_frame(2, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(frm[i], 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    clear_caps();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    frm.delete();
    add_frame(2, 1'b1);
    send_frm(1);
    check_all("after_rst");

    // Random frames of random length, checksum good or bad, with noise and gaps.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      frm.delete();
      add_noise(int'($urandom_range(0, 3)));
      add_frame(int'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0));
      send_frm(2);
      check_all($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_boot_loader.md
# mem_boot_loader

Byte-stream boot loader that sits directly upstream of the three-port SRAM's data port (port 2) and ahead of the processor's reset. It receives a framed program image one byte at a time, assembles big-endian 32-bit words, and writes them to consecutive word addresses with full byte-enables. It holds the processor in reset until a complete frame with a correct checksum has been written.

## Interface
- ADDR_W, default `MEM_ADDR_WIDTH: word-address width, matching the SRAM abus width.
- BASE_WORD, default 0: word address of the first loaded word.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset; one clock.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs on a rising edge with byte_valid & byte_ready.
- mem_addr  out  ADDR_W  word address for SRAM port 2.
- mem_wdata  out  32  word for SRAM dbus2i.
- mem_bwe  out  4  byte write enables; 4'hF during a write cycle, else 4'h0.
- cpu_hold  out  1  high keeps the processor in reset.
- load_done  out  1  level; frame loaded and verified.
- load_err  out  1  sticky; last frame failed its checksum.

## Operation
- Frame format: sync 0xA5, LEN_HI, LEN_LO (16-bit word count N), 4·N data bytes (MSB first per word), CSUM. CSUM is the XOR of all 4·N data bytes, or 0x00 when N=0.
- States and transitions:
  - IDLE: accepts bytes. 0xA5 goes to LEN_HI, clears load_err and the XOR accumulator, and resets word_idx to 0. Any other byte is discarded.
  - LEN_HI: latch count[15:8], go to LEN_LO.
  - LEN_LO: latch count[7:0]. Go to DATA if count≠0, else to CSUM.
  - DATA: shift the byte into the word register and XOR it into the accumulator. On the 4th byte of a word, issue a write and increment word_idx. After the 4th byte of word N-1, go to CSUM.
  - CSUM: if byte == accumulator, go to DONE; else set load_err and go to IDLE.
  - DONE: terminal until reset. byte_ready=0, load_done=1, cpu_hold=0.
- byte_ready = 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE.
- Write address = (BASE_WORD + word_idx) mod 2^ADDR_W. Addresses beyond the top wrap to 0. No error is raised on wrap.
- Already-written words are not rolled back on checksum error. cpu_hold stays 1, so the processor never runs a bad image.
- Reset mid-frame: all state returns to IDLE immediately and partial words are discarded. A new frame must start with 0xA5.

## Timing
- Reset values: byte_ready=1, mem_addr=0, mem_wdata=0, mem_bwe=0, cpu_hold=1, load_done=0, load_err=0. State is IDLE.
- Write latency: the 4th data byte is accepted on edge k. mem_addr, mem_wdata and mem_bwe=4'hF are valid for exactly the cycle after edge k. mem_bwe returns to 0 after edge k+1. All three outputs are registered.
- mem_addr and mem_wdata hold their last values when mem_bwe=0.
- Maximum throughput is one byte per cycle. Gaps in byte_valid only stall the FSM and do not change state.
- load_done=1 and cpu_hold=0 are asserted in the cycle after the edge that accepts a correct CSUM.
- load_err sets in the cycle after the edge that accepts a bad CSUM. It clears in the cycle after the next accepted 0xA5.

## Test plan
- Single word: A5 00 01 DE AD BE EF 22 -> one cycle of mem_bwe=F with mem_addr=0 and mem_wdata=DEADBEEF. Then load_done=1, cpu_hold=0, load_err=0.
- Zero length: A5 00 00 00 -> no write, load_done=1. Variant with CSUM 01 -> load_err=1, load_done=0, cpu_hold=1.
- Error then retry: A5 00 01 11 22 33 44 FF -> load_err=1, back in IDLE. Then a valid 2-word frame -> load_err clears on A5, writes land at addresses 0 and 1, load_done=1.
- Backpressure and noise: leading bytes 00 FF 5A are ignored. Random byte_valid gaps within a 3-word frame -> identical writes at 0, 1, 2. After DONE, byte_ready stays 0.
- Reset mid-frame: rst low after 2 of 4 bytes of word 1 -> all outputs return to their reset values asynchronously. A new full frame then loads correctly from address 0.
- Wrap: BASE_WORD = 2^ADDR_W − 1 with a 2-word frame -> writes at address 2^ADDR_W − 1, then at 0. load_done=1.
